kmp_prefix_builder: RTL

KMP_PREFIX_BUILDER -- requirements
Module: kmp_prefix_builder

---
 rtl/kmp_pkg.sv | 18 +
 rtl/kmp_prefix_table.sv | 35 +++
 rtl/kmp_prefix_builder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/kmp_pkg.sv
// Shared KMP definitions: default geometry and the prefix-builder state encoding,
// used by both the prefix builder and the matcher.
package kmp_pkg;

  localparam int PAT_LEN_DEF = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_Q = 3'd1,
    S_RD_K = 3'd2,
    S_CMP  = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } kmp_state_t;

endpackage

// File: rtl/kmp_prefix_table.sv
// Prefix-function storage: one write port, two combinational read ports
// (builder fallback and matcher lookup). Addresses at or beyond PAT_LEN read as 0.
module kmp_prefix_table #(
  parameter int PAT_LEN = 5,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] rd_b_data
);

  logic [ADDR_W-1:0] mem [PAT_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAT_LEN; i++) mem[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < PAT_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    if (32'(rd_a_addr) < PAT_LEN) rd_a_data = mem[rd_a_addr];
    if (32'(rd_b_addr) < PAT_LEN) rd_b_data = mem[rd_b_addr];
  end

endmodule

// File: rtl/kmp_prefix_builder.sv
// Builds the KMP prefix table pi[] for a pattern read from a synchronous ROM.
// Optional KMP_PREFIX_CYCLES_EN adds a `cycles` port with the last build's edge count.
module kmp_prefix_builder
  import kmp_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  output logic              busy,
  output logic              done,
  output logic              tbl_valid,
  input  logic [ADDR_W-1:0] tbl_addr,
  output logic [ADDR_W-1:0] tbl_data
`ifdef KMP_PREFIX_CYCLES_EN
  ,
  output logic [7:0]        cycles
`endif
);

  localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
  localparam logic [2:0] ST_RD_Q = 3'(S_RD_Q);
  localparam logic [2:0] ST_RD_K = 3'(S_RD_K);
  localparam logic [2:0] ST_CMP  = 3'(S_CMP);
  localparam logic [2:0] ST_NEXT = 3'(S_NEXT);
  localparam logic [2:0] ST_DONE = 3'(S_DONE);

  localparam logic [ADDR_W-1:0] Q_LAST = ADDR_W'(PAT_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] q, k;
  logic [DATA_W-1:0] pq;
  logic              pq_load;
  logic              match;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, wr_data;
  logic [ADDR_W-1:0] fb_data;

  assign match = (pat_data == pq);
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  always_comb begin
    pat_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = q;
    wr_data  = '0;
    case (state)
      ST_IDLE: if (start) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end
      ST_RD_Q: pat_addr = q;
      ST_RD_K: pat_addr = k;
      ST_CMP: begin
        if (match) begin
          wr_en   = 1'b1;
          wr_data = k + ONE;
        end else if (k == '0) begin
          wr_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // pq is captured only on the first RD_K of each q; fallback re-reads keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      q         <= ONE;
      k         <= '0;
      pq        <= '0;
      pq_load   <= 1'b0;
      tbl_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          q         <= ONE;
          k         <= '0;
          tbl_valid <= 1'b0;
          state     <= ST_RD_Q;
        end
        ST_RD_Q: begin
          pq_load <= 1'b1;
          state   <= ST_RD_K;
        end
        ST_RD_K: begin
          if (pq_load) pq <= pat_data;
          pq_load <= 1'b0;
          state   <= ST_CMP;
        end
        ST_CMP: begin
          if (match) begin
            k     <= k + ONE;
            state <= ST_NEXT;
          end else if (k != '0) begin
            k     <= fb_data;
            state <= ST_RD_K;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (q == Q_LAST) begin
            tbl_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            q     <= q + ONE;
            state <= ST_RD_Q;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  kmp_prefix_table #(
    .PAT_LEN (PAT_LEN),
    .ADDR_W  (ADDR_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_a_addr (k - ONE),
    .rd_a_data (fb_data),
    .rd_b_addr (tbl_addr),
    .rd_b_data (tbl_data)
  );

`ifdef KMP_PREFIX_CYCLES_EN
  logic [7:0] cyc_cnt;

  // cyc_cnt counts edges since acceptance; DONE entry is one edge further.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      cycles  <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (start) cyc_cnt <= '0;
      end else if (state != ST_DONE) begin
        if (cyc_cnt != 8'hFF) cyc_cnt <= cyc_cnt + 8'd1;
        if (state == ST_NEXT && q == Q_LAST)
          cycles <= (cyc_cnt == 8'hFF) ? 8'hFF : cyc_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
